frame_receiver: RTL
===================

// Module: frame_receiver
// PURPOSE
//  Far-end receiver for the Transmitter serial link: consumes the bit stream (txOut/txValid),
//  the frame-start strobe (startSeen) and the abort strobe (txAbort), and deserialises each frame.
//  Each frame is a LEN_W-bit length header, MSB first, followed by len words of WORD_W bits, MSB first.
//  Words are buffered in a small FIFO and drained through a valid/ready port. Completion and error
//  are reported as 1-cycle pulses.
// PARAMETERS
//  WORD_W     8   payload word width, in bits
//  LEN_W      8   header width; len = number of words in the frame (0..2^LEN_W-1)
//  FIFO_DEPTH 4   output word FIFO depth; power of 2, >=2
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst        in   1        asynchronous, active-low reset
//  rxIn       in   1        serial data bit; sampled only when rxValid=1
//  rxValid    in   1        rxIn is a valid frame bit in this cycle
//  rxStart    in   1        1-cycle frame-start strobe
//  rxAbort    in   1        1-cycle abort strobe
//  dataOut    out  WORD_W   FIFO head word
//  dataValid  out  1        FIFO not empty
//  dataReady  in   1        consumer accepts dataOut when dataValid&dataReady
//  frameLen   out  LEN_W    header of the current/last frame; held until the next header completes
//  frameDone  out  1        1-cycle pulse: all len words are pushed
//  frameErr   out  1        1-cycle pulse: abort, FIFO overflow, or restart of a frame in progress
//  busy       out  1        1 in states HDR and DATA
// BEHAVIOUR
//  Reset: FSM=IDLE; FIFO empty; all outputs 0 (including dataOut and frameLen).
//  FSM states: IDLE, HDR, DATA, DONE, ERR.
//   IDLE: rxStart -> HDR. Clear the bit counter and word counter. Ignore rxValid.
//   HDR: each rxValid shifts rxIn into len, MSB first. On the LEN_W-th bit, load frameLen.
//     Then go to DONE if len=0, otherwise go to DATA.
//   DATA: each rxValid shifts rxIn into the word register, MSB first.
//     On the WORD_W-th bit, push the word into the FIFO in the same edge and increment wordCnt.
//     When wordCnt reaches len, go to DONE.
//   DONE: frameDone=1 for exactly this cycle, then go to IDLE. An rxStart in DONE goes straight to HDR.
//   ERR: frameErr=1 for exactly this cycle. Flush the FIFO, drop any partial word, then go to IDLE.
//  Latency: the edge that samples the last bit of a word makes dataValid=1 on the next cycle
//   (empty FIFO). frameDone rises in the cycle after the last word is pushed.
//  FIFO: pop on dataValid&dataReady. A push and a pop in the same cycle are legal when full or empty.
//   dataOut is registered at the FIFO head and stays stable while dataValid&~dataReady.
//   The pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//  Errors:
//   - rxAbort in HDR or DATA -> ERR.
//   - A push when full with no simultaneous pop -> ERR (overflow); the word is lost.
//   - rxStart in HDR or DATA -> frameErr pulse and restart in HDR. The FIFO is flushed in the same
//     cycle; there is no visit to IDLE.
//  Simultaneous events: rxAbort beats rxStart beats rxValid. rxAbort in IDLE or DONE is ignored
//   (DONE still pulses frameDone). An rxValid bit arriving in the same cycle as rxStart is not sampled.
//  Word and bit counters are sized to hold len and WORD_W exactly; no wrap within a frame.
//  Reset mid-frame: immediate return to the reset state; no frameErr pulse.
// STRUCTURE
//  Shared package frame_link_pkg: state enum, default WORD_W and LEN_W.
//   The Transmitter uses the same package so that both ends agree on the frame format.
//  Sub-module rx_word_fifo (WIDTH, DEPTH): synchronous FIFO with flush, full, empty and a registered head.
//  Top level: FSM, header and word shift registers, counters.
// TESTING
//  1. Reset, then rxStart, then header 8'h02, then bits of 8'hA5 and 8'h3C with dataReady=1.
//     -> dataOut A5 then 3C; frameDone pulses once; frameLen=2.
//  2. Header 8'h00 -> frameDone pulses in the cycle after the 8th header bit; dataValid stays 0.
//  3. dataReady=0, header 8'h06, 6 words (FIFO_DEPTH=4) -> 5th push overflows.
//     -> frameErr pulse; FIFO flushed; dataValid=0; FSM in IDLE.
//  4. Header 8'h03, 1 word and then 4 bits, then rxAbort -> frameErr pulse; FIFO empty; frameDone never pulses.
//  5. rxStart during DATA, then a full 1-word frame of 8'h81 -> frameErr pulse; only 81 delivered; frameDone once.
//  6. Gapped rxValid (1 bit every 3 cycles) with random dataReady.
//     -> word order and data match a scoreboard; no loss; dataOut stable while stalled.

Source files
------------

// File: rtl/frame_link_pkg.sv
// Shared definitions for both ends of the serial frame link.
// Contents:
//   WORD_W_DEF / LEN_W_DEF - default payload word width and length-header width
//   frame_state_e          - receiver FSM states
//   max_int                - small constant helper for counter sizing
package frame_link_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } frame_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_receiver_if.sv
// Bundle of the serial input strobes and the word output port of frame_receiver.
//   rxIn/rxValid/rxStart/rxAbort : serial bit, bit qualifier, frame-start and abort strobes
//   dataOut/dataValid/dataReady  : word FIFO output handshake
//   frameLen/frameDone/frameErr/busy : frame status
// Modports: slave = the receiver, master = whatever drives the link and consumes words.
interface frame_receiver_if #(
    parameter int WORD_W = frame_link_pkg::WORD_W_DEF,
    parameter int LEN_W  = frame_link_pkg::LEN_W_DEF
);
    logic              rxIn;
    logic              rxValid;
    logic              rxStart;
    logic              rxAbort;
    logic [WORD_W-1:0] dataOut;
    logic              dataValid;
    logic              dataReady;
    logic [LEN_W-1:0]  frameLen;
    logic              frameDone;
    logic              frameErr;
    logic              busy;

    modport master (
        output rxIn, rxValid, rxStart, rxAbort, dataReady,
        input  dataOut, dataValid, frameLen, frameDone, frameErr, busy
    );

    modport slave (
        input  rxIn, rxValid, rxStart, rxAbort, dataReady,
        output dataOut, dataValid, frameLen, frameDone, frameErr, busy
    );
endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO with flush and a registered head word.
//   clk, rst (async, active-low)
//   flush     : empties the FIFO (wins over push/pop)
//   push/push_data : write a word; ignored when full unless a pop happens in the same cycle
//   pop       : remove the head word; ignored when empty
//   head_data : registered copy of the head entry, stable while nothing is popped
//   full, empty
module rx_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop, mem_we;

    // Extra pointer MSB distinguishes full from empty.
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_data = head_q;

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_we  = 1'b0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        head_d  = head_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            mem_we = do_push;
            wr_d   = wr_q + PTR_W'(do_push);
            rd_d   = rd_q + PTR_W'(do_pop);
            // Preload the head for the next cycle; when the new head is the
            // slot being written right now, bypass the array.
            if (wr_d != rd_d) begin
                if (do_push && (rd_d == wr_q))
                    head_d = push_data;
                else
                    head_d = mem[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end
endmodule

// File: rtl/frame_receiver.sv
// Far-end receiver of the serial frame link. A frame is a LEN_W-bit length
// header (MSB first) followed by len words of WORD_W bits (MSB first).
// Completed words go into rx_word_fifo and are drained via dataOut/dataValid/dataReady.
//   clk, rst (async, active-low)
//   bus (slave) : serial strobes in, word port and frame status out
// frameDone pulses in DONE; frameErr pulses on abort, FIFO overflow, or a
// restart of a frame in progress (which goes straight back to HDR).
module frame_receiver
    import frame_link_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    frame_receiver_if.slave   bus
);
    // One bit counter serves both header and word phases.
    localparam int CNT_W = $clog2(max_int(WORD_W, LEN_W) + 1);

    frame_state_e      state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic              err_q, err_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [LEN_W-1:0]  len_shift;
    logic [WORD_W-1:0] word_shift;
    logic [LEN_W-1:0]  word_cnt_inc;

    assign len_shift    = {len_q[LEN_W-2:0], bus.rxIn};
    assign word_shift   = {word_q[WORD_W-2:0], bus.rxIn};
    assign word_cnt_inc = word_cnt_q + LEN_W'(1);
    assign fifo_pop     = bus.dataReady & ~fifo_empty;

    rx_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (word_shift),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        frame_len_d = frame_len_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_d       = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rxStart) begin
                    state_d    = ST_HDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            ST_HDR, ST_DATA: begin
                // Priority: abort, then restart, then a data bit.
                if (bus.rxAbort) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (bus.rxStart) begin
                    state_d    = ST_HDR;
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    word_d     = '0;
                end else if (bus.rxValid) begin
                    if (state_q == ST_HDR) begin
                        len_d = len_shift;
                        if (bit_cnt_q == CNT_W'(LEN_W - 1)) begin
                            frame_len_d = len_shift;
                            bit_cnt_d   = '0;
                            word_cnt_d  = '0;
                            state_d     = (len_shift == '0) ? ST_DONE : ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        word_d = word_shift;
                        if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                            bit_cnt_d = '0;
                            fifo_push = 1'b1;
                            // Full with no pop this cycle: the FIFO drops the word.
                            if (fifo_full && !fifo_pop) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                word_cnt_d = word_cnt_inc;
                                if (word_cnt_inc == len_q)
                                    state_d = ST_DONE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.rxStart) begin
                    state_d    = ST_HDR;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            ST_ERR: begin
                fifo_flush = 1'b1;
                word_d     = '0;
                bit_cnt_d  = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            frame_len_q <= '0;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            frame_len_q <= frame_len_d;
            word_q      <= word_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.dataOut   = fifo_head;
    assign bus.dataValid = ~fifo_empty;
    assign bus.frameLen  = frame_len_q;
    assign bus.frameDone = (state_q == ST_DONE);
    assign bus.frameErr  = err_q;
    assign bus.busy      = (state_q == ST_HDR) || (state_q == ST_DATA);
endmodule
